// File: rtl/req_encoder8_3.sv
// req_encoder8_3: captures 8 request lines into a pending set and offers them
// one at a time as a 3-bit index over a valid/ready output.
// Build option: REQ_ENC_ROUND_ROBIN_EN selects round-robin selection;
// undefined gives fixed priority (bit 7 highest).
//
// Handshake: a transfer happens on a rising clk edge where out_valid=1 and
// out_ready=1. Once out_valid rises it stays high, with code stable, until a
// transfer happens. out_ready is ignored while out_valid=0.
module req_encoder8_3 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [2:0] code,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] pending,
  output logic       ovf
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // state is kept as a plainly named register so checkers can bind to it
  state_t     state;
  state_t     state_next;
  logic       transfer;
  logic       load;
  logic [2:0] sel;
  logic [7:0] load_mask;

`ifdef REQ_ENC_ROUND_ROBIN_EN
  logic [2:0] ptr;
  logic [2:0] idx;
  logic       found;

  // Round-robin pick: first pending bit searching upward from ptr+1, wrapping
  always_comb begin
    sel   = 3'd0;
    idx   = 3'd0;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = ptr + 3'(k);
      if (!found && pending[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  // Pointer remembers the last loaded index; reset value makes index 0 first
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 3'd7;
    end else if (load) begin
      ptr <= sel;
    end
  end
`else
  // Fixed priority pick: highest pending index wins
  always_comb begin
    sel = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pending[i]) begin
        sel = 3'(i);
      end
    end
  end
`endif

  // Handshake decode and the one-hot of the index being loaded this edge
  always_comb begin
    transfer  = out_valid & out_ready;
    load      = ((state == EMPTY) || transfer) && (pending != '0);
    load_mask = load ? (8'd1 << sel) : 8'd0;
  end

  // Next state: loading always fills the slot; a transfer with nothing to
  // load empties it; otherwise hold
  always_comb begin
    state_next = state;
    if (load) begin
      state_next = FULL;
    end else if (transfer) begin
      state_next = EMPTY;
    end
  end

  // State, pending set, output code and overflow pulse registers.
  // A request on the bit being loaded re-sets it (a new event), so it is
  // excluded from the overflow term.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      pending <= 8'h00;
      code    <= 3'd0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_next;
      pending <= (pending & ~load_mask) | req;
      ovf     <= |(req & pending & ~load_mask);
      if (load) begin
        code <= sel;
      end
    end
  end

  assign out_valid = (state == FULL);

endmodule

// File: tb/tb_req_encoder8_3.sv
// Bench for req_encoder8_3: table-driven directed vectors, hand-written
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_req_encoder8_3;

`ifdef REQ_ENC_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // clock / reset block
  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [2:0] code;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] pending;
  logic       ovf;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  req_encoder8_3 dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .code      (code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pending   (pending),
    .ovf       (ovf)
  );

  int checks   = 0;
  int failures = 0;

  // scoreboard: codes the model has loaded, in delivery order
  logic [2:0] exp_q[$];

  // behavioural model state
  logic [7:0] m_pend;
  bit         m_full;
  int         m_code;
  bit         m_ovf;
  int         m_ptr;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // index the model would offer next from its pending set
  function automatic int model_pick();
    int p;
    p = 0;
    if (RR) begin
      for (int k = 8; k >= 1; k--) begin
        if (m_pend[(m_ptr + k) % 8]) p = (m_ptr + k) % 8;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (m_pend[i]) p = i;
      end
    end
    return p;
  endfunction

  // advance the model by one clock edge
  task automatic model_edge(input logic r, input logic [7:0] rq, input logic rd);
    bit xfer;
    bit ld;
    bit lost;
    int s;
    if (r) begin
      m_pend = 8'h00;
      m_full = 1'b0;
      m_code = 0;
      m_ovf  = 1'b0;
      m_ptr  = 7;
      exp_q.delete();
      return;
    end
    xfer = m_full && rd;
    ld   = (!m_full || xfer) && (m_pend != 8'h00);
    s    = model_pick();
    lost = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rq[i] && m_pend[i] && !(ld && i == s)) lost = 1'b1;
    end
    m_ovf = lost;
    if (ld) m_pend[s] = 1'b0;
    m_pend = m_pend | rq;
    if (ld) begin
      m_full = 1'b1;
      m_code = s;
      m_ptr  = s;
      exp_q.push_back(3'(s));
    end else if (xfer) begin
      m_full = 1'b0;
    end
  endtask

  // driver: apply one cycle of inputs, advance model, compare all outputs
  task automatic step(input logic r, input logic [7:0] rq, input logic rd);
    logic       pv;
    logic [2:0] pc;
    @(negedge clk);
    pv        = out_valid;
    pc        = code;
    rst       = r;
    req       = rq;
    out_ready = rd;
    @(posedge clk);
    if (!r && pv && rd) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_transfer", 32'(pc), 32'hFFFF_FFFF);
      end else begin
        check("sb_code", 32'(pc), 32'(exp_q.pop_front()));
      end
    end
    model_edge(r, rq, rd);
    #1;
    check("model_valid", 32'(out_valid), 32'(m_full));
    check("model_code",  32'(code),      32'(m_code));
    check("model_pend",  32'(pending),   32'(m_pend));
    check("model_ovf",   32'(ovf),       32'(m_ovf));
  endtask

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       rdy;
    logic       valid;
    logic [2:0] code;
    logic [7:0] pend;
    logic       ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [7:0] rq, input logic rd,
                              input logic v, input logic [2:0] c, input logic [7:0] p,
                              input logic o);
    vec_t t;
    t.rst = r; t.req = rq; t.rdy = rd; t.valid = v; t.code = c; t.pend = p; t.ovf = o;
    return t;
  endfunction

  initial begin
    rst       = 1'b1;
    req       = 8'h00;
    out_ready = 1'b0;
    m_pend    = 8'h00;
    m_full    = 1'b0;
    m_code    = 0;
    m_ovf     = 1'b0;
    m_ptr     = 7;

    // single pulse
    tbl.push_back(mk(1, 8'h00, 1, 0, 3'd0, 8'h00, 0));
    tbl.push_back(mk(0, 8'h10, 1, 0, 3'd0, 8'h10, 0));
    tbl.push_back(mk(0, 8'h00, 1, 1, 3'd4, 8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 3'd4, 8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 3'd4, 8'h00, 0));
    // backpressure on two events
    tbl.push_back(mk(1, 8'h00, 0, 0, 3'd0, 8'h00, 0));
    tbl.push_back(mk(0, 8'h81, 0, 0, 3'd0, 8'h81, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 8'h00, 0, 1, RR ? 3'd0 : 3'd7, RR ? 8'h80 : 8'h01, 0));
    tbl.push_back(mk(0, 8'h00, 1, 1, RR ? 3'd7 : 3'd0, 8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, RR ? 3'd7 : 3'd0, 8'h00, 0));
    // overflow on an already pending bit
    tbl.push_back(mk(1, 8'h00, 0, 0, 3'd0, 8'h00, 0));
    tbl.push_back(mk(0, 8'h04, 0, 0, 3'd0, 8'h04, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 3'd2, 8'h00, 0));
    tbl.push_back(mk(0, 8'h04, 0, 1, 3'd2, 8'h04, 0));
    tbl.push_back(mk(0, 8'h04, 0, 1, 3'd2, 8'h04, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 3'd2, 8'h04, 0));
    tbl.push_back(mk(0, 8'h00, 1, 1, 3'd2, 8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 3'd2, 8'h00, 0));
    // set wins: request on the bit being loaded is delivered again
    tbl.push_back(mk(1, 8'h00, 1, 0, 3'd0, 8'h00, 0));
    tbl.push_back(mk(0, 8'h20, 1, 0, 3'd0, 8'h20, 0));
    tbl.push_back(mk(0, 8'h20, 1, 1, 3'd5, 8'h20, 0));
    tbl.push_back(mk(0, 8'h00, 1, 1, 3'd5, 8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 3'd5, 8'h00, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].rdy);
      check($sformatf("tbl_valid[%0d]", i), 32'(out_valid), 32'(tbl[i].valid));
      check($sformatf("tbl_code[%0d]", i),  32'(code),      32'(tbl[i].code));
      check($sformatf("tbl_pend[%0d]", i),  32'(pending),   32'(tbl[i].pend));
      check($sformatf("tbl_ovf[%0d]", i),   32'(ovf),       32'(tbl[i].ovf));
    end

    // burst of all eight events, no gaps or repeats
    step(1, 8'h00, 1);
    step(0, 8'hFF, 1);
    check("burst_pend", 32'(pending), 32'h0000_00FF);
    for (int k = 0; k < 8; k++) begin
      step(0, 8'h00, 1);
      check($sformatf("burst_valid[%0d]", k), 32'(out_valid), 32'd1);
      check($sformatf("burst_code[%0d]", k), 32'(code), RR ? 32'(k) : 32'(7 - k));
    end
    step(0, 8'h00, 1);
    check("burst_end_valid", 32'(out_valid), 32'd0);

    // held requests on 0 and 1: RR alternates, fixed priority always picks 1
    step(1, 8'h00, 1);
    step(0, 8'h03, 1);
    for (int k = 0; k < 8; k++) begin
      step(0, 8'h03, 1);
      check($sformatf("fair_valid[%0d]", k), 32'(out_valid), 32'd1);
      check($sformatf("fair_code[%0d]", k), 32'(code), RR ? 32'(k % 2) : 32'd1);
    end

    // reset in the middle of operation discards everything
    step(1, 8'h00, 0);
    step(0, 8'h3C, 0);
    step(0, 8'h3C, 0);
    step(0, 8'h00, 0);
    check("midrst_pre_valid", 32'(out_valid), 32'd1);
    check("midrst_pre_pend", 32'(pending), 32'h0000_003C);
    step(1, 8'hFF, 1);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_code",  32'(code),      32'd0);
    check("midrst_pend",  32'(pending),   32'd0);
    check("midrst_ovf",   32'(ovf),       32'd0);
    for (int k = 0; k < 10; k++) begin
      step(0, 8'h00, 1);
      check($sformatf("midrst_quiet[%0d]", k), 32'(out_valid), 32'd0);
    end

    // randomized traffic against the model
    step(1, 8'h00, 0);
    for (int n = 0; n < 600; n++) begin
      logic       r;
      logic [7:0] rq;
      logic       rd;
      r  = ($urandom_range(0, 79) == 0);
      case ($urandom_range(0, 3))
        0:       rq = 8'($urandom);
        1:       rq = 8'd1 << $urandom_range(0, 7);
        default: rq = 8'h00;
      endcase
      rd = ($urandom_range(0, 3) != 0);
      step(r, rq, rd);
    end

    // drain and confirm every loaded event was delivered
    for (int n = 0; n < 20; n++) step(0, 8'h00, 1);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("drain_valid", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
